// File: rtl/regfile_mp_pkg.sv
// ---------------------------------------------------------------------------
// regfile_mp_pkg
// Definitions shared by decode, execute and the register file:
//   RF_WIDTH  - register data width
//   gf_e      - bank-select encoding (GF_GEN general, GF_FLT float)
//   RF_NREG / RF_NRD / RF_NWR - default bank depth and port counts
// ---------------------------------------------------------------------------
package regfile_mp_pkg;

  localparam int RF_WIDTH = 32;
  localparam int RF_NREG  = 32;
  localparam int RF_NRD   = 3;
  localparam int RF_NWR   = 2;

  typedef enum logic {
    GF_GEN = 1'b0,
    GF_FLT = 1'b1
  } gf_e;

endpackage

// File: rtl/regfile_wsel.sv
// ---------------------------------------------------------------------------
// regfile_wsel
// Resolves which write port, if any, targets a given {gf,num}. When several
// ports match, the highest-numbered port wins.
// Ports:
//   wr_en/wr_gf/wr_num/wr_data - flattened write-port bundle
//   match_gf/match_num         - register being resolved
//   hit                        - at least one write port targets it
//   data                       - write data of the winning port ('0 if no hit)
// ---------------------------------------------------------------------------
module regfile_wsel
  import regfile_mp_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int AW    = 5,
  parameter int NWR   = RF_NWR
) (
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR-1:0]       wr_gf,
  input  logic [NWR*AW-1:0]    wr_num,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic                 match_gf,
  input  logic [AW-1:0]        match_num,
  output logic                 hit,
  output logic [WIDTH-1:0]     data
);

  // Ascending scan: a later matching port overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && (wr_gf[p] == match_gf) && (wr_num[p*AW +: AW] == match_num)) begin
        hit  = 1'b1;
        data = wr_data[p*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Multi-port register file with a general and a float bank, registered
// reads, same-cycle write-to-read bypass and a per-register pending bit.
// Ports:
//   clk, rstn                     - clock, asynchronous active-low reset
//   rd_en/rd_gf/rd_num            - NRD read requests (bank, register)
//   rd_data/rd_busy               - registered read data / pending bit,
//                                   held while rd_en is low
//   wr_en/wr_gf/wr_num/wr_data    - NWR write ports, highest port wins
//   rsv_en/rsv_gf/rsv_num         - mark a register pending
// Flat storage index is {gf,num}; NREG is expected to be a power of two.
// ---------------------------------------------------------------------------
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int NREG    = RF_NREG,
  parameter int NRD     = RF_NRD,
  parameter int NWR     = RF_NWR,
  parameter bit ZERO_R0 = 1'b1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD-1:0]       rd_gf,
  input  logic [NRD*AW-1:0]    rd_num,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR-1:0]       wr_gf,
  input  logic [NWR*AW-1:0]    wr_num,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic                 rsv_en,
  input  logic                 rsv_gf,
  input  logic [AW-1:0]        rsv_num
);

  localparam int NENT = 2 * NREG;

  logic [WIDTH-1:0]     mem       [NENT];
  logic [NENT-1:0]      pend;
  logic [NENT-1:0]      pend_nxt;
  logic [NENT-1:0]      reg_hit;
  logic [NENT-1:0]      reg_we;
  logic [WIDTH-1:0]     reg_wdata [NENT];

  logic [NRD-1:0]       byp_hit;
  logic [WIDTH-1:0]     byp_data  [NRD];
  logic [WIDTH-1:0]     rd_dnxt_p0[NRD];
  logic [NRD-1:0]       rd_bnxt_p0;
  logic [NRD*WIDTH-1:0] rd_data_p1;
  logic [NRD-1:0]       rd_busy_p1;

  // General register 0 is hardwired to zero when ZERO_R0 is set.
  function automatic logic is_zero_reg(input logic [AW:0] idx);
    return ZERO_R0 && (idx == {1'(GF_GEN), {AW{1'b0}}});
  endfunction

  // Per-register write resolution and next pending state. A reservation
  // overrides a same-cycle clear so the newest producer stays tracked.
  for (genvar r = 0; r < NENT; r++) begin : g_reg
    localparam logic [AW:0] RIDX = (AW+1)'(r);

    regfile_wsel #(
      .WIDTH (WIDTH),
      .AW    (AW),
      .NWR   (NWR)
    ) u_wsel_reg (
      .wr_en     (wr_en),
      .wr_gf     (wr_gf),
      .wr_num    (wr_num),
      .wr_data   (wr_data),
      .match_gf  (RIDX[AW]),
      .match_num (RIDX[AW-1:0]),
      .hit       (reg_hit[r]),
      .data      (reg_wdata[r])
    );

    assign reg_we[r]   = reg_hit[r] && !is_zero_reg(RIDX);
    assign pend_nxt[r] = (rsv_en && ({rsv_gf, rsv_num} == RIDX) && !is_zero_reg(RIDX))
                       || (pend[r] && !reg_hit[r]);
  end

  // Read path: bypass same-cycle write data; busy sees the post-update bit.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW:0] ridx;
    assign ridx = {rd_gf[i], rd_num[i*AW +: AW]};

    regfile_wsel #(
      .WIDTH (WIDTH),
      .AW    (AW),
      .NWR   (NWR)
    ) u_wsel_byp (
      .wr_en     (wr_en),
      .wr_gf     (wr_gf),
      .wr_num    (wr_num),
      .wr_data   (wr_data),
      .match_gf  (rd_gf[i]),
      .match_num (rd_num[i*AW +: AW]),
      .hit       (byp_hit[i]),
      .data      (byp_data[i])
    );

    assign rd_dnxt_p0[i] = is_zero_reg(ridx) ? '0
                         : byp_hit[i]        ? byp_data[i]
                         :                     mem[ridx];
    assign rd_bnxt_p0[i] = !is_zero_reg(ridx) && pend_nxt[ridx];
  end

  // ---- stage p0 -> p1: storage, pending bits and read registers ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NENT; r++) mem[r] <= '0;
      pend <= '0;
    end else begin
      for (int r = 0; r < NENT; r++) begin
        if (reg_we[r]) mem[r] <= reg_wdata[r];
      end
      pend <= pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_p1 <= '0;
      rd_busy_p1 <= '0;
    end else begin
      for (int i = 0; i < NRD; i++) begin
        if (rd_en[i]) begin
          rd_data_p1[i*WIDTH +: WIDTH] <= rd_dnxt_p0[i];
          rd_busy_p1[i]                <= rd_bnxt_p0[i];
        end
      end
    end
  end

  assign rd_data = rd_data_p1;
  assign rd_busy = rd_busy_p1;

endmodule
